write_arb_sched: RTL and testbench

Write-channel arbiter and scheduler that shares one downstream AXI3 write address/data channel between two upstream requesters. Requester 0 is the direct (regular-flow) path and requester 1 is the special-memory drain path. It sits between the write-order logic and the slave-side master port. It grants AW bursts round-robin, records grant order in an order FIFO, and routes W beats strictly in AW-grant order, each burst locked to its owner until `wlast`.

---
 rtl/write_arb_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_write_arb_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_arb_sched.sv
// write_arb_sched: shares one AXI3 AW/W channel between two requesters (0 = direct path, 1 = drain path).
// Latency: AW 1 cycle from request to m_awvalid (2 cycles minimum per AW); W path combinational once granted.
// Backpressure: m_awready/m_wready pass straight back to the owning requester; a full order FIFO blocks new AW grants.
//
// Ports:
//   clk, rst               single clock, asynchronous active-high reset
//   s_awvalid/s_awready    per-requester AW handshake, s_aw_pay per-requester packed AW payload (awlen in [LEN_W-1:0])
//   s_wvalid/s_wready      per-requester W handshake, s_wlast and s_w_pay per-requester W last flag and payload
//   m_aw*                  downstream AW channel
//   m_w*                   downstream W channel
//   outstanding            number of granted bursts whose wlast has not yet been accepted
//   busy                   an AW grant is held or a burst is still owed W beats
//   len_err                one-cycle pulse on a burst whose beat count disagrees with awlen
//
// Optional feature: define WRITE_ARB_LEN_CHECK_EN to enable the burst-length checker.
// With it undefined, the order FIFO holds only the source index and len_err is tied low.

// Small synchronous FIFO with a combinational head read.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: push is ignored when full and pop is ignored when empty; the caller watches full/empty.
module write_arb_sched_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing reads an entry before it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module write_arb_sched #(
   parameter int ID_W        = 4,
   parameter int LEN_W       = 4,
   parameter int AW_W        = 48,
   parameter int W_W         = 41,
   parameter int ORDER_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       s_awvalid,
   output logic [1:0]                       s_awready,
   input  logic [1:0][AW_W-1:0]             s_aw_pay,
   input  logic [1:0]                       s_wvalid,
   output logic [1:0]                       s_wready,
   input  logic [1:0]                       s_wlast,
   input  logic [1:0][W_W-1:0]              s_w_pay,
   output logic                             m_awvalid,
   input  logic                             m_awready,
   output logic [AW_W-1:0]                  m_aw_pay,
   output logic                             m_wvalid,
   input  logic                             m_wready,
   output logic                             m_wlast,
   output logic [W_W-1:0]                   m_w_pay,
   output logic [$clog2(ORDER_DEPTH):0]     outstanding,
   output logic                             busy,
   output logic                             len_err
);
   // awid sits in the top ID_W bits of the AW payload; the arbiter passes it through untouched.
   typedef logic [ID_W-1:0] awid_t;

`ifdef WRITE_ARB_LEN_CHECK_EN
   localparam int ENT_W = 1 + LEN_W;   // {source, awlen}
`else
   localparam int ENT_W = 1;           // {source}
`endif

   typedef enum logic {
      AW_IDLE  = 1'b0,
      AW_GRANT = 1'b1
   } aw_state_t;

   aw_state_t                      aw_state;
   logic                           gnt;
   logic                           last_gnt;
   logic                           rr_pick;
   logic                           aw_fire;
   logic                           w_fire;
   logic                           w_pop;
   logic                           head;
   logic [ENT_W-1:0]               push_dat;
   logic [ENT_W-1:0]               head_dat;
   logic [$clog2(ORDER_DEPTH):0]   fifo_cnt;
   logic                           fifo_full;
   logic                           fifo_empty;

   // Round-robin: a tie goes to whoever did not win last; a lone request simply wins.
   always_comb begin
      rr_pick = last_gnt;
      if (s_awvalid == 2'b11) rr_pick = ~last_gnt;
      else                    rr_pick = s_awvalid[1];
   end

   // fifo_full is the registered occupancy, so a pop in the same cycle cannot open the gate early.
   // The grant is frozen for as long as m_awvalid is high, keeping m_aw_pay stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_state  <= AW_IDLE;
         gnt       <= 1'b0;
         last_gnt  <= 1'b1;
         m_awvalid <= 1'b0;
      end else begin
         case (aw_state)
            AW_IDLE: begin
               if ((|s_awvalid) && !fifo_full) begin
                  gnt       <= rr_pick;
                  m_awvalid <= 1'b1;
                  aw_state  <= AW_GRANT;
               end
            end
            AW_GRANT: begin
               if (m_awready) begin
                  last_gnt  <= gnt;
                  m_awvalid <= 1'b0;
                  aw_state  <= AW_IDLE;
               end
            end
            default: begin
               m_awvalid <= 1'b0;
               aw_state  <= AW_IDLE;
            end
         endcase
      end
   end

   assign m_aw_pay = s_aw_pay[gnt];
   assign aw_fire  = m_awvalid && m_awready;

   always_comb begin
      s_awready = 2'b00;
      if (m_awvalid) s_awready[gnt] = m_awready;
   end

`ifdef WRITE_ARB_LEN_CHECK_EN
   assign push_dat = {gnt, s_aw_pay[gnt][LEN_W-1:0]};
`else
   assign push_dat = gnt;
`endif

   // Order FIFO: one entry per accepted AW, popped by the matching wlast handshake.
   // Because the grant only happens when not full and nothing else pushes while granted,
   // the handshake push can never land on a full FIFO.
   write_arb_sched_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (ORDER_DEPTH)
   ) u_order_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (aw_fire),
      .push_dat (push_dat),
      .pop      (w_pop),
      .head_dat (head_dat),
      .count    (fifo_cnt),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // W routing follows the FIFO head; beats for a burst whose AW is not yet accepted simply stall upstream.
   assign head    = head_dat[ENT_W-1];
   assign m_wvalid = !fifo_empty && s_wvalid[head];
   assign m_wlast  = s_wlast[head];
   assign m_w_pay  = s_w_pay[head];
   assign w_fire   = m_wvalid && m_wready;
   assign w_pop    = w_fire && m_wlast;

   always_comb begin
      s_wready = 2'b00;
      if (!fifo_empty) s_wready[head] = m_wready;
   end

   assign outstanding = fifo_cnt;
   assign busy        = m_awvalid || !fifo_empty;

`ifdef WRITE_ARB_LEN_CHECK_EN
   logic [LEN_W:0] beat_cnt;    // beats already accepted in the current burst
   logic [LEN_W:0] beat_num;    // 1-based number of the beat now on the bus
   logic [LEN_W:0] exp_beats;   // awlen + 1

   assign beat_num  = beat_cnt + 1'b1;
   assign exp_beats = {1'b0, head_dat[LEN_W-1:0]} + 1'b1;

   // Flags a wlast that arrives early or late, and a missing wlast on the beat that should have ended the burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         len_err  <= 1'b0;
      end else begin
         len_err <= 1'b0;
         if (w_fire) begin
            if (m_wlast) begin
               beat_cnt <= '0;
               len_err  <= (beat_num != exp_beats);
            end else begin
               beat_cnt <= beat_num;
               len_err  <= (beat_num == exp_beats);
            end
         end
      end
   end
`else
   assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_write_arb_sched.sv
module tb_write_arb_sched;
   localparam int ID_W        = 4;
   localparam int LEN_W       = 4;
   localparam int AW_W        = 48;
   localparam int W_W         = 41;
   localparam int ORDER_DEPTH = 4;
   localparam int CNT_W       = $clog2(ORDER_DEPTH) + 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
   logic [1:0][AW_W-1:0]   s_aw_pay;
   logic [1:0][W_W-1:0]    s_w_pay;
   logic                   m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
   logic [AW_W-1:0]        m_aw_pay;
   logic [W_W-1:0]         m_w_pay;
   logic [CNT_W-1:0]       outstanding;
   logic                   busy, len_err;

   always #5 clk = ~clk;

   write_arb_sched #(
      .ID_W(ID_W), .LEN_W(LEN_W), .AW_W(AW_W), .W_W(W_W), .ORDER_DEPTH(ORDER_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw_pay(s_aw_pay),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_w_pay(s_w_pay),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw_pay(m_aw_pay),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_w_pay(m_w_pay),
      .outstanding(outstanding), .busy(busy), .len_err(len_err)
   );

   int tests = 0;
   int fails = 0;

   // Traffic knobs (percent chance per cycle) and per-requester work lists.
   int pa, pw, ra, rw;
   bit len_test;
   int               len_todo [2][$];
   int               nb_todo  [2][$];
   logic [W_W:0]     w_todo   [2][$];
   // Scoreboard: expected AW payloads and W beats per requester, plus the observed grant order.
   logic [AW_W-1:0]  aw_exp   [2][$];
   logic [W_W:0]     w_exp    [2][$];
   int               order_q  [$];
   logic [AW_W-1:0]  last_aw  [2];
   logic [1:0]       aw_hs, w_hs;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic report_missing(input string name);
      tests++;
      fails++;
      $display("FAIL %s: DUT produced a transfer with no expected entry", name);
   endtask

   function automatic bit roll(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   function automatic bit all_done();
      bit d;
      d = (s_awvalid == 2'b00) && (s_wvalid == 2'b00) && !busy && (order_q.size() == 0);
      for (int s = 0; s < 2; s++)
         d = d && (len_todo[s].size() == 0) && (w_todo[s].size() == 0) &&
             (aw_exp[s].size() == 0) && (w_exp[s].size() == 0);
      return d;
   endfunction

   // One clock of the requester/slave driver: inputs change 1 time unit after the rising edge.
   task automatic step();
      int len, nb;
      logic [AW_W-1:0] pay;
      logic [W_W-1:0]  wp;
      logic [W_W:0]    beat;
      @(negedge clk);
      aw_hs = s_awvalid & s_awready;
      w_hs  = s_wvalid & s_wready;
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         if (s_awvalid[s] && aw_hs[s]) s_awvalid[s] = 1'b0;
         if (!s_awvalid[s] && (len_todo[s].size() > 0) && roll(pa)) begin
            len = len_todo[s].pop_front();
            nb  = nb_todo[s].pop_front();
            pay = AW_W'({$urandom, $urandom});
            pay[AW_W-1 -: ID_W] = ID_W'(s);
            pay[LEN_W-1:0]      = LEN_W'(len);
            s_aw_pay[s]  = pay;
            s_awvalid[s] = 1'b1;
            last_aw[s]   = pay;
            aw_exp[s].push_back(pay);
            for (int b = 0; b < nb; b++) begin
               wp = W_W'({$urandom, $urandom});
               w_todo[s].push_back({(b == nb - 1), wp});
            end
         end
         if (s_wvalid[s] && w_hs[s]) s_wvalid[s] = 1'b0;
         if (!s_wvalid[s] && (w_todo[s].size() > 0) && roll(pw)) begin
            beat = w_todo[s].pop_front();
            s_wlast[s]  = beat[W_W];
            s_w_pay[s]  = beat[W_W-1:0];
            s_wvalid[s] = 1'b1;
            w_exp[s].push_back(beat);
         end
      end
      m_awready = roll(ra);
      m_wready  = roll(rw);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
      s_aw_pay  = '0; s_w_pay  = '0;
      m_awready = 1'b0; m_wready = 1'b0;
      for (int s = 0; s < 2; s++) begin
         len_todo[s].delete(); nb_todo[s].delete(); w_todo[s].delete();
         aw_exp[s].delete();   w_exp[s].delete();
      end
      order_q.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (n < budget && !all_done()) begin
         step();
         n++;
      end
      chk(name, all_done(), 1);
   endtask

   task automatic add_burst(input int s, input int len, input int nb);
      len_todo[s].push_back(len);
      nb_todo[s].push_back(nb);
   endtask

   // Monitor: checks every downstream transfer against the scoreboard, the routing and the round-robin rule.
   initial begin
      int src;
      logic [W_W:0]    wexp;
      logic [1:0]      prev_aw;
      bit              prev_mv;
      bit              rr_last;
      logic [ID_W-1:0] rexp;
      prev_aw = '0; prev_mv = 0; rr_last = 1;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            prev_aw = '0; prev_mv = 0; rr_last = 1;
         end else begin
            chk("outstanding", outstanding, order_q.size());
            if (!len_test) chk("len_err_quiet", len_err, 0);
            if (order_q.size() == 0) begin
               chk("w_closed_when_empty", {s_wready, m_wvalid}, 0);
            end else begin
               src = order_q[0];
               chk("w_valid_route", m_wvalid, s_wvalid[src]);
               chk("w_ready_route", s_wready, (2'(1) << src) & {2{m_wready}});
            end
            // W before AW: an AW accepted this cycle only becomes the head next cycle.
            if (m_wvalid && m_wready) begin
               if (order_q.size() == 0 || w_exp[order_q[0]].size() == 0) begin
                  report_missing("w_beat");
               end else begin
                  src  = order_q[0];
                  wexp = w_exp[src].pop_front();
                  chk("w_beat", {m_wlast, m_w_pay}, wexp);
                  if (m_wlast) void'(order_q.pop_front());
               end
            end
            if (m_awvalid && !prev_mv) begin
               rexp = (prev_aw == 2'b11) ? ID_W'(!rr_last) : ID_W'(prev_aw[1]);
               chk("rr_grant", m_aw_pay[AW_W-1 -: ID_W], rexp);
            end
            if (m_awvalid && m_awready) begin
               chk("aw_ready_onehot", $countones(s_awready), 1);
               src = s_awready[1] ? 1 : 0;
               if (aw_exp[src].size() == 0) begin
                  report_missing("aw_pay");
               end else begin
                  chk("aw_pay", m_aw_pay, aw_exp[src].pop_front());
               end
               order_q.push_back(src);
               rr_last = src[0];
            end
            prev_aw = s_awvalid;
            prev_mv = m_awvalid;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      pa = 100; pw = 100; ra = 100; rw = 100; len_test = 0;
      do_reset();
      chk("rst_m_awvalid", m_awvalid, 0);
      chk("rst_m_wvalid", m_wvalid, 0);
      chk("rst_s_awready", s_awready, 0);
      chk("rst_s_wready", s_wready, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_busy", busy, 0);
      chk("rst_len_err", len_err, 0);

      // Single 4-beat burst on requester 0.
      add_burst(0, 3, 4);
      step(); #1 chk("t1_awvalid_before", m_awvalid, 0);
      step(); #1 chk("t1_awvalid_latency", m_awvalid, 1);
      chk("t1_outstanding_0", outstanding, 0);
      step(); #1 chk("t1_outstanding_1", outstanding, 1);
      chk("t1_busy", busy, 1);
      repeat (3) step();
      #1 chk("t1_still_open", outstanding, 1);
      step(); #1 chk("t1_outstanding_back", outstanding, 0);
      chk("t1_busy_drop", busy, 0);
      drain(20, "t1_drain");

      // Simultaneous requests: requester 0 first, requester 1's W held until 0's wlast.
      do_reset();
      add_burst(0, 1, 2);
      add_burst(1, 1, 2);
      step();
      step(); #1 chk("t2_first_grant", s_awready, 2'b01);
      step(); #1 chk("t2_w_owner0", s_wready, 2'b01);
      step(); #1 chk("t2_second_grant", s_awready, 2'b10);
      chk("t2_w1_held", s_wready, 2'b01);
      step(); #1 chk("t2_w_owner1", s_wready, 2'b10);
      drain(30, "t2_drain");

      // AW backpressure: grant and payload frozen while requester 1 also asks.
      do_reset();
      ra = 0;
      add_burst(0, 1, 2);
      step();
      step();
      add_burst(1, 0, 1);
      repeat (5) begin
         step(); #1;
         chk("t3_awvalid_held", m_awvalid, 1);
         chk("t3_pay_frozen", m_aw_pay, last_aw[0]);
         chk("t3_no_ready", s_awready, 0);
      end
      ra = 100;
      drain(40, "t3_drain");

      // Order FIFO full: a 5th AW waits for a pop and is granted only on the following cycle.
      do_reset();
      rw = 0;
      repeat (5) add_burst(0, 0, 1);
      repeat (12) step();
      #1 chk("t4_full_count", outstanding, 4);
      chk("t4_fifth_blocked", m_awvalid, 0);
      rw = 100;
      step();
      rw = 0;
      step(); #1 chk("t4_after_pop", outstanding, 3);
      chk("t4_not_same_cycle", m_awvalid, 0);
      step(); #1 chk("t4_fifth_granted", m_awvalid, 1);
      rw = 100;
      drain(60, "t4_drain");

      // Short burst: awlen=2 but wlast on beat 2.
      do_reset();
      len_test = 1;
      add_burst(0, 2, 2);
      n = 0;
      repeat (12) begin
         step(); #1;
         if (len_err) n++;
      end
`ifdef WRITE_ARB_LEN_CHECK_EN
      chk("t5_len_err_pulses", n, (2 != 2 + 1) ? 1 : 0);
`else
      chk("t5_len_err_pulses", n, 0);
`endif
      chk("t5_popped", outstanding, 0);
      len_test = 0;
      drain(20, "t5_drain");

      // Reset in the middle of a 4-beat burst.
      do_reset();
      add_burst(0, 3, 4);
      repeat (5) step();
      #1 chk("t6_mid_burst", outstanding, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_m_awvalid", m_awvalid, 0);
      chk("t6_m_wvalid", m_wvalid, 0);
      chk("t6_s_awready", s_awready, 0);
      chk("t6_s_wready", s_wready, 0);
      chk("t6_outstanding", outstanding, 0);
      chk("t6_busy", busy, 0);
      chk("t6_len_err", len_err, 0);
      do_reset();

      // Random traffic with random backpressure on both sides.
      pa = 70; pw = 70; ra = 60; rw = 60;
      for (int i = 0; i < 25; i++) begin
         for (int s = 0; s < 2; s++) begin
            n = $urandom_range(0, 3);
            add_burst(s, n, n + 1);
         end
      end
      drain(4000, "rand_drain_a");
      pa = 100; pw = 90; ra = 90; rw = 30;
      for (int i = 0; i < 20; i++) begin
         n = $urandom_range(0, 3);
         add_burst($urandom_range(0, 1), n, n + 1);
      end
      drain(4000, "rand_drain_b");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
